// File: rtl/system_memory_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : system_memory_reader
// Purpose  : Avalon-MM read master that streams a block of words out through a
//            small FIFO. The optional running word sum is enabled by defining
//            SYSTEM_MEMORY_READER_SUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module system_memory_reader #(
  parameter int ADDR_W     = 17,
  parameter int MEM_WORDS  = 78036,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W-1:0] address,
  output logic              chipselect,
  output logic              write,
  output logic [3:0]        byteenable,
  output logic [31:0]       writedata,
  output logic              clken,
  input  logic [31:0]       readdata,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       sum
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(MEM_WORDS - 1);
  localparam logic [c_ptr_w+1:0] c_depth = (c_ptr_w+2)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [ADDR_W-1:0] r_address;
  logic [ADDR_W-1:0] r_remaining;
  logic              r_inflight;
  logic              r_aborted;

  logic [31:0]        r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;

  logic               w_start_acc;
  logic               w_abort_act;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic               w_credit;
  logic [c_ptr_w+1:0] w_occ;

  assign w_start_acc = start && (r_state == S_IDLE);
  assign w_abort_act = abort && ((r_state == S_READ) || (r_state == S_DRAIN));

  // Occupancy counts words already buffered plus the one still on the bus,
  // less any word leaving this cycle, so a return always has a slot.
  assign w_occ    = {1'b0, r_count}
                  + {{(c_ptr_w+1){1'b0}}, r_inflight}
                  - {{(c_ptr_w+1){1'b0}}, w_pop};
  assign w_credit = (w_occ < c_depth);

  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rd_ptr];
  assign w_pop     = out_valid && out_ready;
  assign w_push    = r_inflight && !w_abort_act;
  assign w_issue   = chipselect;

  assign address    = r_address;
  assign write      = 1'b0;
  assign byteenable = 4'hF;
  assign writedata  = 32'h0000_0000;
  assign clken      = 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    chipselect   = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    aborted      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          busy         = 1'b1;
          w_state_next = (word_count == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        busy       = 1'b1;
        chipselect = w_credit && !abort;
        if (abort) begin
          w_state_next = S_DONE;
        end else if (chipselect && (r_remaining == ADDR_W'(1))) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (abort || (!r_inflight && (r_count == '0))) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        aborted      = r_aborted;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_address   <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_inflight <= chipselect;
      if (w_start_acc) begin
        r_address   <= base_addr;
        r_remaining <= word_count;
        r_aborted   <= 1'b0;
      end else begin
        if (w_issue) begin
          r_address   <= (r_address == c_last_addr) ? '0 : r_address + 1'b1;
          r_remaining <= r_remaining - 1'b1;
        end
        if (w_abort_act) begin
          r_aborted <= 1'b1;
        end
      end
    end
  end

  // Output FIFO; an abort flushes it and drops any word still returning.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_abort_act) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= readdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef SYSTEM_MEMORY_READER_SUM_EN
  logic [31:0] r_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sum <= '0;
    end else if (w_start_acc) begin
      r_sum <= '0;
    end else if (w_pop) begin
      r_sum <= r_sum + out_data;
    end
  end

  assign sum = r_sum;
`else
  assign sum = 32'h0000_0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_system_memory_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_system_memory_reader
// Purpose  : Scoreboard bench for system_memory_reader with a 1-cycle memory
//            model (memory[i] = i). Sum checks follow SYSTEM_MEMORY_READER_SUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_system_memory_reader;

  localparam int ADDR_W     = 17;
  localparam int MEM_WORDS  = 78036;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] word_count = '0;
  logic              abort = 1'b0;
  logic              busy, done, aborted;
  logic [ADDR_W-1:0] address;
  logic              chipselect, write, clken;
  logic [3:0]        byteenable;
  logic [31:0]       writedata;
  logic [31:0]       readdata = '0;
  logic [31:0]       out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       sum;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int cs_cnt = 0;
  int pop_cnt = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int first_pop_cyc = 0;
  int last_pop_cyc = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  system_memory_reader #(
    .ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .abort(abort), .busy(busy), .done(done),
    .aborted(aborted), .address(address), .chipselect(chipselect),
    .write(write), .byteenable(byteenable), .writedata(writedata),
    .clken(clken), .readdata(readdata), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    readdata <= chipselect ? 32'(address) : 32'h0;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (int'(a) + 1 == MEM_WORDS) ? '0 : a + 1'b1;
  endfunction

  // Bus and stream monitor: compares issued addresses and popped words.
  always @(negedge clk) begin
    if (!reset) begin
      if (chipselect) begin
        cs_cnt++;
        if (exp_addr_q.size() == 0) check_value("addr_unexpected", 32'(address), 32'hFFFF_FFFF);
        else check_value("addr", 32'(address), exp_addr_q.pop_front());
      end
      if (out_valid && out_ready) begin
        if (pop_cnt == 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        pop_cnt++;
        if (exp_data_q.size() == 0) check_value("data_unexpected", out_data, 32'hFFFF_FFFF);
        else check_value("data", out_data, exp_data_q.pop_front());
      end
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
  end

  task automatic do_start(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] count);
    logic [ADDR_W-1:0] a;
    a = base;
    for (int i = 0; i < int'(count); i++) begin
      exp_addr_q.push_back(32'(a));
      exp_data_q.push_back(32'(a));
      a = next_addr(a);
    end
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; word_count = count;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic ab);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check_value("done_timeout", 32'd0, 32'd1);
    ab = aborted;
  endtask

  initial begin
    logic ab;
    int   npop;
    int   d_snap;
    logic [31:0] exp_sum;

    // Reset state
    repeat (2) @(posedge clk); #1;
    check_value("rst_address", 32'(address), 32'h0);
    check_value("rst_cs", 32'(chipselect), 32'h0);
    check_value("rst_busy", 32'(busy), 32'h0);
    check_value("rst_done", 32'(done), 32'h0);
    check_value("rst_valid", 32'(out_valid), 32'h0);
    check_value("rst_data", out_data, 32'h0);
    check_value("rst_sum", sum, 32'h0);
    check_value("tie_write", 32'(write), 32'h0);
    check_value("tie_be", 32'(byteenable), 32'hF);
    check_value("tie_clken", 32'(clken), 32'h1);
    check_value("tie_wdata", writedata, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Basic 4-word transfer
    out_ready = 1'b1; pop_cnt = 0; done_cnt = 0;
    do_start(17'h00010, 17'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_value("t1_cs", 32'(chipselect), 32'h1);
    end
    @(negedge clk);
    check_value("t1_cs_end", 32'(chipselect), 32'h0);
    wait_done(20, ab);
    check_value("t1_busy_at_done", 32'(busy), 32'h0);
    check_value("t1_aborted", 32'(ab), 32'h0);
    check_value("t1_pops", 32'(pop_cnt), 32'd4);
    check_value("t1_back2back", 32'(last_pop_cyc - first_pop_cyc), 32'd3);
`ifdef SYSTEM_MEMORY_READER_SUM_EN
    exp_sum = 32'h46;
`else
    exp_sum = 32'h0;
`endif
    check_value("t1_sum", sum, exp_sum);
    @(negedge clk);
    check_value("t1_done_pulse", 32'(done), 32'h0);
    check_value("t1_done_cnt", 32'(done_cnt), 32'd1);
    check_value("t1_q_empty", 32'(exp_data_q.size() + exp_addr_q.size()), 32'd0);

    // Address wrap at the top of memory
    pop_cnt = 0;
    do_start(17'd78034, 17'd4);
    wait_done(30, ab);
    @(negedge clk);
    check_value("t2_pops", 32'(pop_cnt), 32'd4);
    check_value("t2_q_empty", 32'(exp_data_q.size() + exp_addr_q.size()), 32'd0);
`ifdef SYSTEM_MEMORY_READER_SUM_EN
    exp_sum = 32'd156070;
`else
    exp_sum = 32'h0;
`endif
    check_value("t2_sum", sum, exp_sum);

    // Backpressure: credit limits reads to the FIFO depth
    out_ready = 1'b0; cs_cnt = 0; pop_cnt = 0;
    do_start(17'h00100, 17'd8);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 5) check_value("t3_hold_mid", out_data, 32'h100);
    end
    check_value("t3_cs_cnt", 32'(cs_cnt), 32'd4);
    check_value("t3_valid", 32'(out_valid), 32'h1);
    check_value("t3_hold_end", out_data, 32'h100);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done(60, ab);
    @(negedge clk);
    check_value("t3_pops", 32'(pop_cnt), 32'd8);
    check_value("t3_q_empty", 32'(exp_data_q.size() + exp_addr_q.size()), 32'd0);

    // Zero-length transfer
    cs_cnt = 0; busy_cnt = 0; done_cnt = 0;
    do_start(17'h00040, 17'd0);
    @(negedge clk);
    check_value("t4_done", 32'(done), 32'h1);
    check_value("t4_busy", 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    check_value("t4_cs_cnt", 32'(cs_cnt), 32'd0);
    check_value("t4_busy_cnt", 32'(busy_cnt), 32'd1);
    check_value("t4_done_cnt", 32'(done_cnt), 32'd1);

    // Abort on the third popped word; a second start is ignored
    pop_cnt = 0;
    do_start(17'h00200, 17'd100);
    start = 1'b1; base_addr = 17'h05000; word_count = 17'd3;
    @(posedge clk); #1;
    start = 1'b0;
    npop = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) npop++;
      if (npop == 2) break;
    end
    check_value("t5_pops_seen", 32'(npop), 32'd2);
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk);
    check_value("t5_cs_abort", 32'(chipselect), 32'h0);
    check_value("t5_busy_abort", 32'(busy), 32'h1);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check_value("t5_valid_after", 32'(out_valid), 32'h0);
    check_value("t5_done", 32'(done), 32'h1);
    check_value("t5_aborted", 32'(aborted), 32'h1);
    check_value("t5_pops", 32'(pop_cnt), 32'd3);
    exp_addr_q.delete();
    exp_data_q.delete();

    // Asynchronous reset mid-transfer, then a normal run
    pop_cnt = 0;
    do_start(17'h00300, 17'd50);
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_value("t6_address", 32'(address), 32'h0);
    check_value("t6_cs", 32'(chipselect), 32'h0);
    check_value("t6_busy", 32'(busy), 32'h0);
    check_value("t6_done", 32'(done), 32'h0);
    check_value("t6_valid", 32'(out_valid), 32'h0);
    check_value("t6_data", out_data, 32'h0);
    check_value("t6_sum", sum, 32'h0);
    d_snap = done_cnt;
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_value("t6_no_done", 32'(done_cnt), 32'(d_snap));
    pop_cnt = 0;
    do_start(17'd5, 17'd2);
    wait_done(30, ab);
    check_value("t6_aborted", 32'(ab), 32'h0);
    @(negedge clk);
    check_value("t6_pops", 32'(pop_cnt), 32'd2);
    check_value("t6_q_empty", 32'(exp_data_q.size() + exp_addr_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
